// File: rtl/serial_byte_feeder.sv
// Byte-to-serial feeder with a one-entry holding buffer and optional inter-frame gap.
// Define SERIAL_MSB_FIRST_EN to emit DIN[7] first instead of DIN[0].
module serial_byte_feeder #(
   parameter int   FRAME_GAP = 0,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] DIN,
   input  logic       VALID,
   output logic       READY,
   output logic       SO,
   output logic       BUSY,
   output logic       FRAME_DONE
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   localparam logic [3:0] GAP_LOAD =
      (FRAME_GAP > 0) ? 4'(FRAME_GAP - 1) : 4'd0;

   state_t     state, state_n;
   logic [7:0] sh, sh_n;
   logic [2:0] cnt, cnt_n;
   logic [7:0] hold_q, hold_n;
   logic       full, full_n;
   logic [3:0] gap_cnt, gap_n;
   logic       done_q, done_n;
   logic       accept;
   logic       slot;
   logic [7:0] sh_next;
   logic       sh_bit;

`ifdef SERIAL_MSB_FIRST_EN
   assign sh_next = {sh[6:0], 1'b0};
   assign sh_bit  = sh[7];
`else
   assign sh_next = {1'b0, sh[7:1]};
   assign sh_bit  = sh[0];
`endif

   assign READY      = !full;
   assign accept     = VALID && !full;
   assign SO         = (state == S_SHIFT) ? sh_bit : IDLE_BIT;
   assign BUSY       = (state != S_IDLE) || full;
   assign FRAME_DONE = done_q;

   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      hold_n  = hold_q;
      full_n  = full;
      gap_n   = gap_cnt;
      done_n  = 1'b0;
      slot    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               sh_n    = DIN;
               cnt_n   = 3'd0;
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sh_n  = sh_next;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
               done_n = 1'b1;
               if (FRAME_GAP > 0) begin
                  state_n = S_GAP;
                  gap_n   = GAP_LOAD;
               end else begin
                  slot = 1'b1;
               end
            end
            if (accept && !slot) begin
               hold_n = DIN;
               full_n = 1'b1;
            end
         end
         S_GAP: begin
            if (gap_cnt == 4'd0) slot = 1'b1;
            else gap_n = gap_cnt - 4'd1;
            if (accept && !slot) begin
               hold_n = DIN;
               full_n = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // buffered byte has priority; READY is low then, so DIN cannot collide
      if (slot) begin
         cnt_n   = 3'd0;
         state_n = S_SHIFT;
         if (full) begin
            sh_n   = hold_q;
            full_n = 1'b0;
         end else if (accept) begin
            sh_n = DIN;
         end else begin
            state_n = S_IDLE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         sh      <= 8'd0;
         cnt     <= 3'd0;
         hold_q  <= 8'd0;
         full    <= 1'b0;
         gap_cnt <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         sh      <= sh_n;
         cnt     <= cnt_n;
         hold_q  <= hold_n;
         full    <= full_n;
         gap_cnt <= gap_n;
         done_q  <= done_n;
      end
   end

endmodule

// File: tb/tb_serial_byte_feeder.sv
// Bench for serial_byte_feeder: frame-level model plus directed literal checks.
// Two instances run side by side, FRAME_GAP = 0 and FRAME_GAP = 2.
module tb_serial_byte_feeder;

   localparam logic IDLE = 1'b0;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [7:0] DIN = 8'h00;
   logic       VALID = 1'b0;
   logic [1:0] ready, so, busy, done;

   int gp [2] = '{0, 2};
   int pass = 0;
   int tot = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   always #5 CLK = ~CLK;

   serial_byte_feeder #(.FRAME_GAP(0), .IDLE_BIT(IDLE)) u0 (
      .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .VALID(VALID),
      .READY(ready[0]), .SO(so[0]), .BUSY(busy[0]), .FRAME_DONE(done[0])
   );

   serial_byte_feeder #(.FRAME_GAP(2), .IDLE_BIT(IDLE)) u1 (
      .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .VALID(VALID),
      .READY(ready[1]), .SO(so[1]), .BUSY(busy[1]), .FRAME_DONE(done[1])
   );

   // byte the downstream register ends up holding for a sent byte
   function automatic logic [7:0] ds_byte(input logic [7:0] b);
      logic [7:0] r;
`ifdef SERIAL_MSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
      r = b;
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] req);
      tot++;
      if (act === req) pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)",
                    name, act, req, cyc);
   endtask

   // frame-level model: position within the current frame slot
   logic       m_act [2];
   logic [7:0] m_cur [2];
   logic [4:0] m_pos [2];
   logic       m_bf  [2];
   logic [7:0] m_buf [2];
   logic       m_done [2];

   initial begin
      for (int u = 0; u < 2; u++) begin
         m_act[u] = 0; m_cur[u] = 0; m_pos[u] = 0;
         m_bf[u] = 0; m_buf[u] = 0; m_done[u] = 0;
      end
   end

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int u = 0; u < 2; u++) begin
            m_act[u] <= 1'b0;
            m_pos[u] <= 5'd0;
            m_bf[u] <= 1'b0;
            m_done[u] <= 1'b0;
         end
      end else begin
         for (int u = 0; u < 2; u++) begin
            m_done[u] <= m_act[u] && (m_pos[u] == 5'd7);
            if (!m_act[u]) begin
               if (VALID) begin
                  m_act[u] <= 1'b1;
                  m_cur[u] <= DIN;
                  m_pos[u] <= 5'd0;
               end
            end else if (m_pos[u] == 5'(7 + gp[u])) begin
               if (m_bf[u]) begin
                  m_cur[u] <= m_buf[u];
                  m_bf[u] <= 1'b0;
                  m_pos[u] <= 5'd0;
               end else if (VALID) begin
                  m_cur[u] <= DIN;
                  m_pos[u] <= 5'd0;
               end else begin
                  m_act[u] <= 1'b0;
               end
            end else begin
               m_pos[u] <= m_pos[u] + 5'd1;
               if (VALID && !m_bf[u]) begin
                  m_buf[u] <= DIN;
                  m_bf[u] <= 1'b1;
               end
            end
         end
      end
   end

   logic [7:0] ds [2];
   logic so_h [2][4096];
   logic rdy_h [2][4096];
   logic done_h [2][4096];
   logic [7:0] got0 [$];
   logic [7:0] got1 [$];

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      for (int u = 0; u < 2; u++) ds[u] <= {so[u], ds[u][7:1]};
   end

   always @(negedge CLK) begin
      for (int u = 0; u < 2; u++) begin
         so_h[u][cyc[11:0]] = so[u];
         rdy_h[u][cyc[11:0]] = ready[u];
         done_h[u][cyc[11:0]] = done[u];
      end
      if (done[0]) got0.push_back(ds[0]);
      if (done[1]) got1.push_back(ds[1]);
      if (chk_en) begin
         for (int u = 0; u < 2; u++) begin
            logic e_so;
            e_so = IDLE;
            if (m_act[u] && m_pos[u] < 5'd8)
               e_so = ds_byte(m_cur[u])[m_pos[u][2:0]];
            check($sformatf("model_so%0d", u), 16'(so[u]), 16'(e_so));
            check($sformatf("model_ready%0d", u), 16'(ready[u]),
                  16'(!m_bf[u]));
            check($sformatf("model_busy%0d", u), 16'(busy[u]),
                  16'(m_act[u] || m_bf[u]));
            check($sformatf("model_done%0d", u), 16'(done[u]),
                  16'(m_done[u]));
         end
      end
   end

   task automatic send(input int u, input logic [7:0] b, output int k);
      k = 0;
      for (int i = 0; i < 100; i++) begin
         if (ready[u]) begin
            VALID = 1'b1;
            DIN = b;
            @(posedge CLK);
            #1 k = cyc;
            @(negedge CLK);
            VALID = 1'b0;
            return;
         end
         @(negedge CLK);
      end
      check("send_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (busy == 2'b00) begin
            repeat (2) @(negedge CLK);
            return;
         end
         @(negedge CLK);
      end
      check("idle_timeout", 16'd0, 16'd1);
   endtask

   task automatic chk_frame(input int u, input int k, input logic [7:0] b,
                            input string name);
      logic [7:0] s;
      logic [7:0] e;
      e = ds_byte(b);
      for (int i = 0; i < 8; i++) s[i] = so_h[u][k+i];
      check({name, "_so_bits"}, 16'(s), 16'(e));
   endtask

   int k, k2;
   logic [7:0] e;

   initial begin
      RST_N = 1'b0;
      VALID = 1'b1;
      DIN = 8'hFF;
      repeat (3) @(negedge CLK);
      check("rst_so", 16'(so[0]), 16'(IDLE));
      check("rst_ready", 16'(ready[0]), 16'd1);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      chk_en = 1'b1;
      VALID = 1'b0;
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_no_accept", 16'(busy), 16'd0);

      got0.delete();
      send(0, 8'hA5, k);
      repeat (10) @(negedge CLK);
      chk_frame(0, k, 8'hA5, "a5");
      check("a5_done_early", 16'(done_h[0][k+7]), 16'd0);
      check("a5_done", 16'(done_h[0][k+8]), 16'd1);
      check("a5_done_late", 16'(done_h[0][k+9]), 16'd0);
      check("a5_count", 16'(got0.size()), 16'd1);
      if (got0.size() > 0) check("a5_out", 16'(got0[0]), 16'h00A5);

      wait_idle();
      got0.delete();
      send(0, 8'h01, k);
      repeat (10) @(negedge CLK);
      chk_frame(0, k, 8'h01, "x01");
      e = ds_byte(8'h01);
      if (got0.size() > 0) check("x01_out", 16'(got0[0]), 16'(e));
      else check("x01_count", 16'd0, 16'd1);

      wait_idle();
      got0.delete();
      send(0, 8'h3C, k);
      send(0, 8'hC3, k2);
      check("b2b_edges", 16'(k2 - k), 16'd1);
      repeat (20) @(negedge CLK);
      chk_frame(0, k, 8'h3C, "b2b_first");
      chk_frame(0, k + 8, 8'hC3, "b2b_second");
      check("b2b_ready_lo1", 16'(rdy_h[0][k+1]), 16'd0);
      check("b2b_ready_lo7", 16'(rdy_h[0][k+7]), 16'd0);
      check("b2b_ready_hi8", 16'(rdy_h[0][k+8]), 16'd1);
      check("b2b_done8", 16'(done_h[0][k+8]), 16'd1);
      check("b2b_done16", 16'(done_h[0][k+16]), 16'd1);
      check("b2b_count", 16'(got0.size()), 16'd2);
      if (got0.size() == 2) begin
         check("b2b_out0", 16'(got0[0]), 16'h003C);
         check("b2b_out1", 16'(got0[1]), 16'h00C3);
      end

      wait_idle();
      got1.delete();
      send(1, 8'h5A, k);
      send(1, 8'hC3, k2);
      repeat (24) @(negedge CLK);
      chk_frame(1, k, 8'h5A, "gap_first");
      check("gap_idle0", 16'(so_h[1][k+8]), 16'(IDLE));
      check("gap_idle1", 16'(so_h[1][k+9]), 16'(IDLE));
      chk_frame(1, k + 10, 8'hC3, "gap_second");
      check("gap_done8", 16'(done_h[1][k+8]), 16'd1);
      check("gap_done18", 16'(done_h[1][k+18]), 16'd1);
      check("gap_count", 16'(got1.size()), 16'd2);

      wait_idle();
      send(0, 8'hF0, k);
      repeat (3) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      check("mid_rst_busy", 16'(busy), 16'd0);
      RST_N = 1'b1;
      got0.delete();
      @(negedge CLK);
      send(0, 8'h81, k);
      repeat (12) @(negedge CLK);
      chk_frame(0, k, 8'h81, "x81");
      check("x81_count", 16'(got0.size()), 16'd1);
      e = ds_byte(8'h81);
      if (got0.size() > 0) check("x81_out", 16'(got0[0]), 16'(e));

      wait_idle();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass, tot);
      $finish;
   end

endmodule
